// File: rtl/packing_stage.sv
// Bit packer: concatenates up to two right-aligned codewords per cycle MSB-first
// into an accumulator and emits fixed-width words; flush pads the tail and tags it last.
module packing_stage #(
    parameter int OUT_WIDTH = 64,
    parameter int CW_WIDTH  = 34,
    parameter int ACC_WIDTH = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CW_WIDTH-1:0]  i_cw1,
    input  logic [5:0]           i_len1,
    input  logic [CW_WIDTH-1:0]  i_cw2,
    input  logic [5:0]           i_len2,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic [CNT_WIDTH-1:0] o_bit_count
);
    localparam int PAIR_W = 2 * CW_WIDTH;
    localparam int FILL_W = $clog2(ACC_WIDTH + 1);
    localparam int SUM_W  = $clog2(PAIR_W + 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [FILL_W-1:0]      r_cnt;
    logic [CNT_WIDTH-1:0]   r_bit_count;

    logic [5:0]             w_len1, w_len2;
    logic [CW_WIDTH-1:0]    w_cw1, w_cw2;
    logic [SUM_W-1:0]       w_sum;
    logic [PAIR_W-1:0]      w_pair, w_pair_l;
    logic [ACC_WIDTH-1:0]   w_ins;
    logic                   w_valid, w_push, w_pop;
    logic [FILL_W-1:0]      w_cnt_run;

    // Over-long lengths saturate; bits above the length are masked off.
    assign w_len1 = (i_len1 > 6'(CW_WIDTH)) ? 6'(CW_WIDTH) : i_len1;
    assign w_len2 = (i_len2 > 6'(CW_WIDTH)) ? 6'(CW_WIDTH) : i_len2;
    assign w_cw1  = i_cw1 & ~({CW_WIDTH{1'b1}} << w_len1);
    assign w_cw2  = i_cw2 & ~({CW_WIDTH{1'b1}} << w_len2);
    assign w_sum  = SUM_W'(w_len1) + SUM_W'(w_len2);

    // Join the pair, left-align it, then drop it just below the current fill.
    assign w_pair   = (PAIR_W'(w_cw1) << w_len2) | PAIR_W'(w_cw2);
    assign w_pair_l = w_pair << (SUM_W'(PAIR_W) - w_sum);
    assign w_ins    = {w_pair_l, {(ACC_WIDTH-PAIR_W){1'b0}}} >> r_cnt;

    assign o_ready = (r_state == S_RUN) && (r_cnt <= FILL_W'(ACC_WIDTH - PAIR_W));
    assign w_valid = (r_state == S_RUN) ? (r_cnt >= FILL_W'(OUT_WIDTH)) : (r_cnt != '0);
    assign o_valid = w_valid;
    assign o_last  = (r_state == S_FLUSH) && (r_cnt != '0) && (r_cnt <= FILL_W'(OUT_WIDTH));
    assign o_data  = r_acc[ACC_WIDTH-1 -: OUT_WIDTH];
    assign o_bit_count = r_bit_count;

    assign w_push = i_valid && o_ready;
    assign w_pop  = w_valid && i_ready;

    always_comb begin
        w_cnt_run = r_cnt;
        if (w_push)
            w_cnt_run = r_cnt + FILL_W'(w_sum);
        else if (w_pop)
            w_cnt_run = r_cnt - FILL_W'(OUT_WIDTH);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_RUN;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bit_count <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // o_ready and o_valid never overlap here, so push and pop cannot collide.
                    if (w_push) begin
                        r_acc       <= r_acc | w_ins;
                        r_bit_count <= r_bit_count + CNT_WIDTH'(w_sum);
                    end else if (w_pop) begin
                        r_acc <= r_acc << OUT_WIDTH;
                    end
                    r_cnt <= w_cnt_run;
                    if (i_flush && (w_cnt_run != '0))
                        r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_pop) begin
                        r_acc <= r_acc << OUT_WIDTH;
                        if (r_cnt <= FILL_W'(OUT_WIDTH)) begin
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_cnt <= r_cnt - FILL_W'(OUT_WIDTH);
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_packing_stage.sv
// Bench for packing_stage: directed cases plus random traffic, checked every
// cycle against a bit-queue model of the stream.
module tb_packing_stage;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
    logic [33:0] i_cw1 = '0, i_cw2 = '0;
    logic [5:0]  i_len1 = '0, i_len2 = '0;
    logic        o_ready, o_valid, o_last;
    logic [63:0] o_data;
    logic [31:0] o_bit_count;

    packing_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_cw1(i_cw1), .i_len1(i_len1), .i_cw2(i_cw2), .i_len2(i_len2),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_bit_count(o_bit_count)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: the pending stream as a queue of bits, first bit at the front.
    bit          q[$];
    bit          m_flush = 1'b0;
    logic [31:0] m_bits = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic append(input logic [33:0] cw, input int len);
        for (int i = len - 1; i >= 0; i--) q.push_back(cw[i]);
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 1'b0;
        m_bits  = '0;
    endtask

    // One clock: drive at negedge, check against the model, advance the model.
    task automatic cyc(input logic v, input logic [33:0] c1, input logic [5:0] l1,
                       input logic [33:0] c2, input logic [5:0] l2,
                       input logic fl, input logic rd);
        logic [63:0] e_data;
        logic        e_ready, e_valid, e_last, was_flush;
        int          s1, s2, n;
        i_valid = v; i_cw1 = c1; i_len1 = l1; i_cw2 = c2; i_len2 = l2;
        i_flush = fl; i_ready = rd;
        #1;
        e_ready = !m_flush && (q.size() <= 60);
        e_valid = m_flush ? (q.size() > 0) : (q.size() >= 64);
        e_last  = m_flush && (q.size() > 0) && (q.size() <= 64);
        e_data  = '0;
        for (int i = 0; i < 64; i++) if (i < q.size()) e_data[63-i] = q[i];
        chk("ready", 64'(o_ready), 64'(e_ready));
        chk("valid", 64'(o_valid), 64'(e_valid));
        chk("last", 64'(o_last), 64'(e_last));
        chk("bitcnt", 64'(o_bit_count), 64'(m_bits));
        if (e_valid) chk("data", o_data, e_data);
        was_flush = m_flush;
        if (v && e_ready) begin
            s1 = (l1 > 34) ? 34 : int'(l1);
            s2 = (l2 > 34) ? 34 : int'(l2);
            append(c1, s1);
            append(c2, s2);
            m_bits += 32'(s1 + s2);
        end
        if (e_valid && rd) begin
            n = (q.size() < 64) ? q.size() : 64;
            for (int i = 0; i < n; i++) void'(q.pop_front());
        end
        if (!was_flush && fl && q.size() != 0) m_flush = 1'b1;
        else if (was_flush && q.size() == 0)   m_flush = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic idle(input logic fl, input logic rd);
        cyc(1'b0, '0, '0, '0, '0, fl, rd);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_bits", 64'(o_bit_count), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        idle(1'b0, 1'b1);
        chk("idle_ready", 64'(o_ready), 64'd1);

        // Eight 0xDA pairs fill exactly one word
        for (int k = 0; k < 8; k++) cyc(1'b1, 34'hD, 6'd4, 34'hA, 6'd4, 1'b0, 1'b1);
        chk("dada_valid", 64'(o_valid), 64'd1);
        chk("dada_data", o_data, 64'hDADADADADADADADA);
        chk("dada_last", 64'(o_last), 64'd0);
        chk("dada_bits", 64'(o_bit_count), 64'd64);
        idle(1'b0, 1'b1);
        chk("dada_drained", 64'(o_valid), 64'd0);

        // Short codeword with flush in the same cycle
        cyc(1'b1, 34'h5, 6'd3, 34'h0, 6'd0, 1'b1, 1'b1);
        chk("fl3_data", o_data, 64'hA000000000000000);
        chk("fl3_last", 64'(o_last), 64'd1);
        chk("fl3_ready", 64'(o_ready), 64'd0);
        idle(1'b0, 1'b1);
        chk("fl3_back", 64'(o_ready), 64'd1);

        // Backpressure: 68 bits buffered, word held, further push refused
        cyc(1'b1, 34'h3_FFFF_FFFF, 6'd34, 34'h0, 6'd34, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 34'h1F, 6'd5, 34'h0, 6'd0, 1'b0, 1'b0);
            chk("hold_data", o_data, 64'hFFFFFFFFC0000000);
            chk("hold_ready", 64'(o_ready), 64'd0);
        end
        idle(1'b0, 1'b1);
        chk("bp_ready", 64'(o_ready), 64'd1);
        chk("bp_valid", 64'(o_valid), 64'd0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);

        // Flush with 68 bits: one full word then a padded last word
        cyc(1'b1, 34'h3_FFFF_FFFF, 6'd34, 34'h0, 6'd34, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        chk("f68_w0", o_data, 64'hFFFFFFFFC0000000);
        chk("f68_l0", 64'(o_last), 64'd0);
        idle(1'b0, 1'b1);
        chk("f68_w1", o_data, 64'h0);
        chk("f68_v1", 64'(o_valid), 64'd1);
        chk("f68_l1", 64'(o_last), 64'd1);
        idle(1'b0, 1'b1);
        chk("f68_back", 64'(o_ready), 64'd1);

        // Reset in the middle of a flush
        cyc(1'b1, 34'h3_FFFF_FFFF, 6'd34, 34'h0, 6'd34, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_reset = 1'b0;
        #1;
        model_reset();
        chk("mrst_valid", 64'(o_valid), 64'd0);
        chk("mrst_data", o_data, 64'd0);
        chk("mrst_bits", 64'(o_bit_count), 64'd0);
        @(negedge i_clk);
        chk("mrst_valid2", 64'(o_valid), 64'd0);
        chk("mrst_last2", 64'(o_last), 64'd0);
        i_reset = 1'b1;
        idle(1'b0, 1'b1);

        // Masking and length saturation
        cyc(1'b1, 34'h3_FFFF_FFFF, 6'd2, 34'h0, 6'd40, 1'b0, 1'b1);
        chk("sat_bits", 64'(o_bit_count), 64'd36);
        idle(1'b1, 1'b0);
        chk("sat_data", o_data, 64'hC000000000000000);
        chk("sat_last", 64'(o_last), 64'd1);
        idle(1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 3) != 0),
                34'({$urandom(), $urandom()}), 6'($urandom_range(0, 40)),
                34'({$urandom(), $urandom()}), 6'($urandom_range(0, 40)),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end

        // Drain whatever is left
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0 && !m_flush) break;
            idle(!m_flush, 1'b1);
        end
        chk("drain_valid", 64'(o_valid), 64'd0);
        chk("drain_ready", 64'(o_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/packing_stage.md
Name: packing_stage

Overview:
- Downstream neighbour of the matching stage in the compression datapath (Stateg1).
- Consumes up to two variable-length codewords per cycle; each is right-aligned, up to 34 bits, with its length.
- Concatenates them MSB-first into a contiguous bitstream and emits fixed 64-bit words to the output buffer over a valid/ready handshake.
- Provides a flush that zero-pads the stream tail to a word boundary and marks the final word.

Parameters:
- OUT_WIDTH, 64, output word width.
- CW_WIDTH, 34, maximum codeword width (2-bit code + 32-bit literal).
- ACC_WIDTH, 128, accumulator depth in bits; must be ≥ 2*OUT_WIDTH.
- CNT_WIDTH, 32, width of the total packed-bit counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_valid  in  1  codeword pair valid.
- o_ready  out  1  pair accepted when i_valid && o_ready.
- i_cw1  in  CW_WIDTH  first codeword, right-aligned; earlier in the stream.
- i_len1  in  6  length of i_cw1 in bits, 0..34.
- i_cw2  in  CW_WIDTH  second codeword, right-aligned.
- i_len2  in  6  length of i_cw2 in bits, 0..34.
- i_flush  in  1  end-of-stream request; single-cycle pulse.
- o_valid  out  1  o_data holds a complete (or final padded) word.
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_data  out  OUT_WIDTH  packed word; first stream bit at bit 63.
- o_last  out  1  qualifies the final word of a flush.
- o_bit_count  out  CNT_WIDTH  total codeword bits accepted since reset.

Behaviour:
- State: accumulator acc[127:0], fill count cnt (0..128), FSM {S_RUN, S_FLUSH}, bit counter. Valid bits occupy acc[127:128-cnt].
- Reset (i_reset=0, asynchronous): acc=0, cnt=0, state=S_RUN, o_bit_count=0. Outputs during and after reset: o_valid=0, o_last=0, o_data=0; o_ready=1 once reset is released.
- Input masking: bits of i_cw above i_len are ignored. A length >34 is a protocol violation; the design saturates it to 34.
- o_ready = (state==S_RUN) && (cnt ≤ ACC_WIDTH-2*CW_WIDTH), i.e. cnt ≤ 60. This guarantees no overflow.
- Push (i_valid && o_ready): append cw1 then cw2 directly after the current valid bits; cnt += len1+len2; o_bit_count += len1+len2, wrapping modulo 2^32. A zero-length pair is accepted as a no-op on acc and cnt.
- S_RUN output:
  - o_valid = (cnt ≥ 64); o_data = acc[127:64].
  - Pop (o_valid && i_ready): acc shifts left 64, zero-filled; cnt -= 64.
  - Push and pop are mutually exclusive in S_RUN, because o_valid implies cnt > 60.
  - o_data is held stable while o_valid && !i_ready.
- Latency: a word is presented the cycle after the push that makes cnt ≥ 64.
- i_flush is sampled only in S_RUN.
  - If a push occurs in the same cycle, that pair is included before flushing.
  - If the resulting cnt == 0, stay in S_RUN and emit nothing.
  - Otherwise go to S_FLUSH.
- i_flush is ignored in S_FLUSH.
- S_FLUSH:
  - o_ready=0; o_valid = (cnt > 0); o_data = acc[127:64], with bits below the valid region already zero.
  - o_last = o_valid && (cnt ≤ 64).
  - On handshake: cnt = max(cnt-64, 0), acc shifts left 64.
  - After the o_last handshake, return to S_RUN with cnt=0.
- A flush reached with cnt in 65..128 emits one full word and then one padded last word.
- Reset mid-stream or mid-flush discards all buffered bits. No partial word is emitted afterward.

Test Plan:
- Reset then idle → o_valid=0, o_ready=1, o_data=0, o_bit_count=0. Assert reset mid-flush → same values on the next cycle.
- Eight pushes of cw1=4'b1101/len 4 and cw2=4'b1010/len 4, with i_ready=1 → after the 8th accept, o_valid=1 one cycle later with o_data=64'hDADADADADADADADA and o_last=0; o_bit_count=64, cnt back to 0.
- Push cw1=3'b101/len 3, len2=0, with i_flush in the same cycle → one word o_data=64'hA000000000000000 with o_last=1, then return to S_RUN with o_ready=1.
- i_ready=0; push cw1=34'h3_FFFF_FFFF/34 and cw2=34'h0/34 → cnt=68, o_ready=0, and a second pending push is not accepted. o_data=64'hFFFFFFFFC0000000 is held for 5 cycles. Raise i_ready → pop, cnt=4, o_ready=1.
- From cnt=68 (previous case, i_ready=0), pulse i_flush → S_FLUSH. Then i_ready=1 → two words: 64'hFFFFFFFFC0000000 with o_last=0, then 64'h0 with o_last=1.
- Mask and saturate check: cw1=34'h3_FFFF_FFFF with len1=2, cw2=0 with len2=40 (saturated to 34) → cnt=36, o_bit_count=36. Flush → o_data=64'hC000000000000000, o_last=1.
